// File: rtl/atmega_uart_pkg.sv
// Shared constants for the atmega_uart bus-master sequencer: register bit positions,
// controller state encoding and UCSRB init values. RX path gated by ATMEGA_UART_CTRL_RX_EN.
package atmega_uart_pkg;

  localparam int unsigned UcsraRxcBit  = 7;
  localparam int unsigned UcsraUdreBit = 5;
  localparam int unsigned UcsrbRxenBit = 4;
  localparam int unsigned UcsrbTxenBit = 3;

  localparam logic [7:0] UcsrbInitTx   = 8'(1 << UcsrbTxenBit);
  localparam logic [7:0] UcsrbInitRxTx = 8'((1 << UcsrbTxenBit) | (1 << UcsrbRxenBit));

`ifdef ATMEGA_UART_CTRL_RX_EN
  typedef enum logic [2:0] {
    StInitH, StInitL, StInitC, StInitB, StPoll, StRdUdr, StWrUdr
  } ctrl_state_e;
`else
  typedef enum logic [2:0] {
    StInitH, StInitL, StInitC, StInitB, StPoll, StWrUdr
  } ctrl_state_e;
`endif

  function automatic logic [7:0] ucsrb_init(input bit rx_en);
    return rx_en ? UcsrbInitRxTx : UcsrbInitTx;
  endfunction

endpackage

// File: rtl/atmega_uart_ctrl_fifo.sv
// Synchronous FIFO for the TX byte stream; push is accepted when full only alongside a pop.
module atmega_uart_ctrl_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PtrW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (PtrW+1)'(1);
    end
  end

endmodule

// File: rtl/atmega_uart_ctrl.sv
// Bus-master sequencer replacing a CPU in front of atmega_uart: init, then poll UCSRA and
// move bytes between streams and UDR. Define ATMEGA_UART_CTRL_RX_EN to build the RX path.
module atmega_uart_ctrl
  import atmega_uart_pkg::*;
#(
  parameter int unsigned                  BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UDR_ADDR   = BUS_ADDR_DATA_LEN'(8'hc1),
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRA_ADDR = BUS_ADDR_DATA_LEN'(8'hc8),
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRB_ADDR = BUS_ADDR_DATA_LEN'(8'hc9),
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRC_ADDR = BUS_ADDR_DATA_LEN'(8'hca),
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UBRRL_ADDR = BUS_ADDR_DATA_LEN'(8'hcc),
  parameter logic [BUS_ADDR_DATA_LEN-1:0] UBRRH_ADDR = BUS_ADDR_DATA_LEN'(8'hcd),
  parameter logic [11:0]                  UBRR_INIT  = 12'd103,
  parameter logic [7:0]                   UCSRC_INIT = 8'h06,
  parameter int unsigned                  TX_FIFO_DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  output logic [BUS_ADDR_DATA_LEN-1:0] addr_o,
  output logic                         wr_o,
  output logic                         rd_o,
  output logic [7:0]                   dat_o,
  input  logic [7:0]                   dat_i,
  input  logic                         cfg_reload_i,
  input  logic [7:0]                   tx_data_i,
  input  logic                         tx_valid_i,
  output logic                         tx_ready_o,
  output logic [7:0]                   rx_data_o,
  output logic                         rx_valid_o,
  input  logic                         rx_ready_i,
  output logic                         busy_o
);

`ifdef ATMEGA_UART_CTRL_RX_EN
  localparam bit RxEn = 1'b1;
`else
  localparam bit RxEn = 1'b0;
`endif
  localparam logic [7:0] UcsrbInit = ucsrb_init(RxEn);

  ctrl_state_e state_q;
  logic        reload_pend_q;
  logic        udre_q;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [7:0]  fifo_head;
  logic        in_init;

  assign tx_ready_o = rst_i & ~fifo_full;
  assign fifo_push  = tx_valid_i & tx_ready_o;
  assign fifo_pop   = (state_q == StWrUdr);

  atmega_uart_ctrl_fifo #(
    .Width (8),
    .Depth (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (tx_data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef ATMEGA_UART_CTRL_RX_EN
  logic       rx_valid_q;
  logic [7:0] rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{dat_i, rx_ready_i};
  assign rx_valid_o    = 1'b0;
  assign rx_data_o     = 8'h00;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= StInitH;
      reload_pend_q <= 1'b0;
      udre_q        <= 1'b1;
`ifdef ATMEGA_UART_CTRL_RX_EN
      rx_valid_q    <= 1'b0;
      rx_data_q     <= 8'h00;
`endif
    end else begin
      if (cfg_reload_i) reload_pend_q <= 1'b1;
`ifdef ATMEGA_UART_CTRL_RX_EN
      if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;
`endif
      unique case (state_q)
        StInitH: state_q <= StInitL;
        StInitL: state_q <= StInitC;
        StInitC: state_q <= StInitB;
        StInitB: state_q <= StPoll;
        StPoll: begin
          udre_q <= dat_i[UcsraUdreBit];
          // A pending reload outranks data movement; a reload pulse this cycle re-arms it.
          if (reload_pend_q) begin
            state_q       <= StInitH;
            reload_pend_q <= cfg_reload_i;
`ifdef ATMEGA_UART_CTRL_RX_EN
          end else if (dat_i[UcsraRxcBit] && !rx_valid_q) begin
            state_q <= StRdUdr;
`endif
          end else if (dat_i[UcsraUdreBit] && !fifo_empty) begin
            state_q <= StWrUdr;
          end
        end
`ifdef ATMEGA_UART_CTRL_RX_EN
        StRdUdr: begin
          rx_data_q  <= dat_i;
          rx_valid_q <= 1'b1;
          state_q    <= StPoll;
        end
`endif
        StWrUdr: state_q <= StPoll;
        default: state_q <= StInitH;
      endcase
    end
  end

  assign in_init = (state_q == StInitH) || (state_q == StInitL) ||
                   (state_q == StInitC) || (state_q == StInitB);
  assign busy_o  = rst_i & (in_init | ~fifo_empty | ~udre_q);

  always_comb begin
    addr_o = '0;
    wr_o   = 1'b0;
    rd_o   = 1'b0;
    dat_o  = 8'h00;
    if (rst_i) begin
      unique case (state_q)
        StInitH: begin wr_o = 1'b1; addr_o = UBRRH_ADDR; dat_o = {4'h0, UBRR_INIT[11:8]}; end
        StInitL: begin wr_o = 1'b1; addr_o = UBRRL_ADDR; dat_o = UBRR_INIT[7:0];          end
        StInitC: begin wr_o = 1'b1; addr_o = UCSRC_ADDR; dat_o = UCSRC_INIT;              end
        StInitB: begin wr_o = 1'b1; addr_o = UCSRB_ADDR; dat_o = UcsrbInit;               end
        StPoll:  begin rd_o = 1'b1; addr_o = UCSRA_ADDR;                                  end
`ifdef ATMEGA_UART_CTRL_RX_EN
        StRdUdr: begin rd_o = 1'b1; addr_o = UDR_ADDR;                                    end
`endif
        StWrUdr: begin wr_o = 1'b1; addr_o = UDR_ADDR;   dat_o = fifo_head;               end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atmega_uart_ctrl.sv
// Directed bench for atmega_uart_ctrl with a minimal UART register model on the bus.
// Follows ATMEGA_UART_CTRL_RX_EN to select RX-path or RX-disabled expectations.
module tb_atmega_uart_ctrl;

  localparam logic [7:0] AUdr   = 8'hc1;
  localparam logic [7:0] AUcsra = 8'hc8;
`ifdef ATMEGA_UART_CTRL_RX_EN
  localparam logic [7:0] ExpUcsrb = 8'h18;
`else
  localparam logic [7:0] ExpUcsrb = 8'h08;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] addr_o, dat_o, dat_i, tx_data, rx_data_o;
  logic       wr_o, rd_o, cfg_reload, tx_valid, tx_ready_o, rx_valid_o, rx_ready, busy_o;
  logic       rxc, udre;
  logic [7:0] uart_rx_byte;

  int checks = 0;
  int failures = 0;
  logic [7:0] udr_log[$];
  int udr_rd_cnt = 0;

  always #5 clk = ~clk;

  // UART register model: UCSRA reflects RXC/UDRE, UDR returns the pending receive byte.
  assign dat_i = (rd_o && addr_o == AUcsra) ? {rxc, 1'b0, udre, 5'b0} :
                 (rd_o && addr_o == AUdr)   ? uart_rx_byte : 8'h00;

  atmega_uart_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .addr_o       (addr_o),
    .wr_o         (wr_o),
    .rd_o         (rd_o),
    .dat_o        (dat_o),
    .dat_i        (dat_i),
    .cfg_reload_i (cfg_reload),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready_o),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready),
    .busy_o       (busy_o)
  );

  always @(negedge clk) begin
    if (rst_n && wr_o && addr_o == AUdr) udr_log.push_back(dat_o);
    if (rst_n && rd_o && addr_o == AUdr) udr_rd_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus(input string tag, input logic wr, input logic rd,
                           input logic [7:0] addr, input logic [7:0] dat);
    check_eq(tag, {wr_o, rd_o, addr_o, dat_o}, {wr, rd, addr, dat});
  endtask

  task automatic check_init_seq(input string tag);
    check_bus({tag, "_ubrrh"}, 1'b1, 1'b0, 8'hcd, 8'h00);
    check_eq({tag, "_busy"}, busy_o, 1);
    tick;
    check_bus({tag, "_ubrrl"}, 1'b1, 1'b0, 8'hcc, 8'h67);
    tick;
    check_bus({tag, "_ucsrc"}, 1'b1, 1'b0, 8'hca, 8'h06);
    tick;
    check_bus({tag, "_ucsrb"}, 1'b1, 1'b0, 8'hc9, ExpUcsrb);
    tick;
    check_bus({tag, "_poll"}, 1'b0, 1'b1, AUcsra, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; cfg_reload = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    rxc = 1'b0; udre = 1'b1; uart_rx_byte = 8'h00;
    repeat (3) tick;
    check_bus("rst_bus", 1'b0, 1'b0, 8'h00, 8'h00);
    check_eq("rst_tx_ready", tx_ready_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_rx", {rx_valid_o, rx_data_o}, 0);

    rst_n = 1'b1;
    #1;
    check_init_seq("init");
    tick;
    check_bus("poll_again", 1'b0, 1'b1, AUcsra, 8'h00);
    check_eq("idle_busy", busy_o, 0);

    // Two bytes: first written two cycles after push, second waits for UDRE to come back.
    udr_log.delete();
    tx_data = 8'h55; tx_valid = 1'b1;
    check_eq("a_ready", tx_ready_o, 1);
    tick;
    tx_data = 8'hA3;
    tick;
    check_bus("a_wr55", 1'b1, 1'b0, AUdr, 8'h55);
    tx_valid = 1'b0; udre = 1'b0;
    tick;
    check_bus("a_poll_busy1", 1'b0, 1'b1, AUcsra, 8'h00);
    tick;
    check_bus("a_poll_busy2", 1'b0, 1'b1, AUcsra, 8'h00);
    check_eq("a_busy", busy_o, 1);
    udre = 1'b1;
    tick;
    check_bus("a_wrA3", 1'b1, 1'b0, AUdr, 8'hA3);
    tick;
    tick;
    check_eq("a_idle_busy", busy_o, 0);
    check_eq("a_log_size", udr_log.size(), 2);

    // Fill 16 entries while UART is busy; 17th must wait and then go out in order.
    udr_log.delete();
    udre = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tx_data = 8'h10 + 8'(i); tx_valid = 1'b1;
      check_eq("b_fill_ready", tx_ready_o, 1);
      tick;
    end
    tx_data = 8'h20;
    check_eq("b_full_ready", tx_ready_o, 0);
    repeat (3) tick;
    check_eq("b_full_hold_ready", tx_ready_o, 0);
    check_eq("b_full_no_wr", udr_log.size(), 0);
    udre = 1'b1;
    for (int c = 0; c < 100 && udr_log.size() < 17; c++) begin
      if (tx_valid && tx_ready_o) begin
        tick;
        tx_valid = 1'b0;
      end else begin
        tick;
      end
    end
    check_eq("b_drain_count", udr_log.size(), 17);
    for (int i = 0; i < 17 && i < udr_log.size(); i++)
      check_eq("b_drain_byte", udr_log[i], (i < 16) ? 32'h10 + i : 32'h20);

    // RXC and UDRE in the same poll with a queued TX byte.
    udre = 1'b0;
    tx_data = 8'h77; tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
    tick;
    check_bus("c_pre_poll", 1'b0, 1'b1, AUcsra, 8'h00);
    rxc = 1'b1; udre = 1'b1; uart_rx_byte = 8'hC3;
    tick;
`ifdef ATMEGA_UART_CTRL_RX_EN
    check_bus("c_rd_first", 1'b0, 1'b1, AUdr, 8'h00);
    rxc = 1'b0;
    tick;
    check_eq("c_rx_out", {rx_valid_o, rx_data_o}, {1'b1, 8'hC3});
    tick;
    check_bus("c_wr_after", 1'b1, 1'b0, AUdr, 8'h77);
    tick;

    // Held byte blocks further UDR reads until the consumer accepts it.
    rxc = 1'b1; uart_rx_byte = 8'h5A;
    begin
      int base;
      base = udr_rd_cnt;
      repeat (5) tick;
      check_eq("d_no_read", udr_rd_cnt, base);
      check_eq("d_held", {rx_valid_o, rx_data_o}, {1'b1, 8'hC3});
      rx_ready = 1'b1;
      tick;
      rx_ready = 1'b0;
      check_eq("d_cleared", rx_valid_o, 0);
      for (int c = 0; c < 10 && !rx_valid_o; c++) tick;
      check_eq("d_new_byte", {rx_valid_o, rx_data_o}, {1'b1, 8'h5A});
      check_eq("d_one_read", udr_rd_cnt, base + 1);
    end
    rxc = 1'b0;
    rx_ready = 1'b1;
    tick;
    rx_ready = 1'b0;
`else
    check_bus("c_rx_ignored", 1'b1, 1'b0, AUdr, 8'h77);
    check_eq("c_rx_off", {rx_valid_o, rx_data_o}, 0);
    rx_ready = 1'b1;
    tick;
    rx_ready = 1'b0;
    check_eq("c_no_udr_read", udr_rd_cnt, 0);
    check_eq("c_rx_still_off", {rx_valid_o, rx_data_o}, 0);
    rxc = 1'b0;
`endif

    // Reload during a UDR write: write finishes, init reruns, queued byte follows.
    udr_log.delete();
    udre = 1'b0;
    tx_data = 8'h81; tx_valid = 1'b1;
    tick;
    tx_data = 8'h82;
    tick;
    tx_valid = 1'b0;
    udre = 1'b1;
    begin
      bit found;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        if (wr_o && addr_o == AUdr) found = 1'b1;
        else tick;
      end
      check_eq("e_wr_seen", found, 1);
    end
    check_eq("e_wr_byte", dat_o, 8'h81);
    cfg_reload = 1'b1;
    tick;
    cfg_reload = 1'b0;
    check_bus("e_poll", 1'b0, 1'b1, AUcsra, 8'h00);
    tick;
    check_init_seq("e_reinit");
    for (int c = 0; c < 10 && udr_log.size() < 2; c++) tick;
    check_eq("e_log_size", udr_log.size(), 2);
    if (udr_log.size() >= 2) begin
      check_eq("e_log0", udr_log[0], 8'h81);
      check_eq("e_log1", udr_log[1], 8'h82);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
